pixel_packer: RTL

PIXEL_PACKER -- requirements
Module: pixel_packer

---
 rtl/pixel_packer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pixel_packer.sv
// Packs clamped 8-bit pixels four per 32-bit word, tags line/frame ends and
// buffers the words in a first-word-fall-through FIFO with overflow accounting.
module pixel_packer #(
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_pixel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_eol,
    output logic        out_eof,
    output logic        ovf_sticky,
    input  logic        ovf_clr,
    output logic [7:0]  drop_cnt,
    output logic [15:0] frame_cnt
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [1:0]    lane;
    logic [CW-1:0] column;
    logic [RW-1:0] row;
    logic [23:0]   partial;
    logic [7:0]    clamped;

    logic          push_req;
    logic          end_of_line;
    logic          end_of_frame;

    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [33:0]   head;

    // Signed saturation of the incoming pixel to the 0..255 range
    always_comb begin
        clamped = in_pixel[7:0];
        if (in_pixel[31]) begin
            clamped = 8'h00;
        end else if (|in_pixel[30:8]) begin
            clamped = 8'hFF;
        end
    end

    assign push_req     = in_valid && (lane == 2'd3);
    assign end_of_line  = (column == COL_LAST);
    assign end_of_frame = end_of_line && (row == ROW_LAST);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop   = !empty && out_ready;
    assign push  = push_req && (!full || pop);
    assign drop  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            lane      <= 2'd0;
            column    <= '0;
            row       <= '0;
            partial   <= '0;
            frame_cnt <= '0;
        end else if (in_valid) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    partial[7:0]   <= clamped;
                2'd1:    partial[15:8]  <= clamped;
                2'd2:    partial[23:16] <= clamped;
                default: partial        <= partial;
            endcase
            if (end_of_line) begin
                column <= '0;
                if (row == ROW_LAST) begin
                    row       <= '0;
                    frame_cnt <= frame_cnt + 16'd1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                column <= column + 1'b1;
            end
        end
    end

    // Storage carries {eof, eol, data}; it needs no reset because the
    // pointers define which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr[AW-1:0]] <= {end_of_frame, end_of_line, clamped, partial};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // A clear wins over a drop landing on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else if (drop) begin
            ovf_sticky <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_data  = empty ? 32'd0 : head[31:0];
    assign out_eol   = !empty && head[32];
    assign out_eof   = !empty && head[33];

endmodule
